// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD
   } state_e;

   // Active-high segment patterns, bit 0 = a ... bit 6 = g
   localparam logic [6:0] PAT_0     = 7'h3F;
   localparam logic [6:0] PAT_1     = 7'h06;
   localparam logic [6:0] PAT_2     = 7'h5B;
   localparam logic [6:0] PAT_3     = 7'h4F;
   localparam logic [6:0] PAT_4     = 7'h66;
   localparam logic [6:0] PAT_5     = 7'h6D;
   localparam logic [6:0] PAT_6     = 7'h7D;
   localparam logic [6:0] PAT_7     = 7'h07;
   localparam logic [6:0] PAT_8     = 7'h7F;
   localparam logic [6:0] PAT_9     = 7'h6F;
   localparam logic [6:0] PAT_A     = 7'h77;
   localparam logic [6:0] PAT_B     = 7'h7C;
   localparam logic [6:0] PAT_C     = 7'h39;
   localparam logic [6:0] PAT_D     = 7'h5E;
   localparam logic [6:0] PAT_E     = 7'h79;
   localparam logic [6:0] PAT_F     = 7'h71;
   localparam logic [6:0] PAT_BLANK = 7'h00;

   localparam int DEF_STABLE_CYCLES  = 16;
   localparam int DEF_TIMEOUT_CYCLES = 100_000_000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of an active-high seven-segment pattern into a hex nibble.
module seg7_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic [3:0] nibble_o,
   output logic       valid_o,
   output logic       blank_o
);

   always_comb begin
      nibble_o = 4'h0;
      valid_o  = 1'b1;
      blank_o  = 1'b0;
      case (pattern_i)
         PAT_0:     nibble_o = 4'h0;
         PAT_1:     nibble_o = 4'h1;
         PAT_2:     nibble_o = 4'h2;
         PAT_3:     nibble_o = 4'h3;
         PAT_4:     nibble_o = 4'h4;
         PAT_5:     nibble_o = 4'h5;
         PAT_6:     nibble_o = 4'h6;
         PAT_7:     nibble_o = 4'h7;
         PAT_8:     nibble_o = 4'h8;
         PAT_9:     nibble_o = 4'h9;
         PAT_A:     nibble_o = 4'hA;
         PAT_B:     nibble_o = 4'hB;
         PAT_C:     nibble_o = 4'hC;
         PAT_D:     nibble_o = 4'hD;
         PAT_E:     nibble_o = 4'hE;
         PAT_F:     nibble_o = 4'hF;
         PAT_BLANK: begin
            valid_o = 1'b0;
            blank_o = 1'b1;
         end
         default:   valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed active-low seven-segment bus and decodes each digit once its drive settles.
// Define SEG_SCAN_DECODER_SYNC_EN to insert a two-flop synchronizer ahead of the sample register.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   input  logic        dp,
   output logic [15:0] digits,
   output logic [3:0]  valid,
   output logic [3:0]  blank,
   output logic [3:0]  dp_out,
   output logic        frame_done,
   output logic        stale,
   output logic        multi_err
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

   logic [11:0] inS;
   logic [11:0] sampleQ, prevQ;

`ifdef SEG_SCAN_DECODER_SYNC_EN
   logic [11:0] sync1Q, sync2Q;

   // Reset to all-ones so the bus looks undriven until real samples arrive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1Q <= '1;
         sync2Q <= '1;
      end else begin
         sync1Q <= {an, seg, dp};
         sync2Q <= sync1Q;
      end
   end

   assign inS = sync2Q;
`else
   assign inS = {an, seg, dp};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sampleQ <= '1;
         prevQ   <= '1;
      end else begin
         sampleQ <= inS;
         prevQ   <= sampleQ;
      end
   end

   logic [3:0] anQ;
   logic [6:0] segQ;
   logic       dpQ;
   logic       sampleChanged;
   logic       singleAnode;
   logic       multiAnode;
   logic [1:0] anIdx;

   assign anQ           = sampleQ[11:8];
   assign segQ          = sampleQ[7:1];
   assign dpQ           = sampleQ[0];
   assign sampleChanged = (sampleQ != prevQ);

   always_comb begin
      singleAnode = 1'b1;
      anIdx       = 2'd0;
      case (anQ)
         4'b1110: anIdx = 2'd0;
         4'b1101: anIdx = 2'd1;
         4'b1011: anIdx = 2'd2;
         4'b0111: anIdx = 2'd3;
         default: singleAnode = 1'b0;
      endcase
   end

   assign multiAnode = !singleAnode && (anQ != 4'b1111);

   state_e           stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             commit;
   logic             reeval;
   logic             multiErrD;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= ST_IDLE;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   // Any sample change drops back to the IDLE decision in the same cycle
   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      commit    = 1'b0;
      reeval    = 1'b0;
      multiErrD = 1'b0;
      case (stateQ)
         ST_SETTLE: begin
            if (sampleChanged) begin
               reeval = 1'b1;
            end else if (cntQ == CNT_LAST) begin
               commit = 1'b1;
               stateD = ST_HOLD;
            end else begin
               cntD = cntQ + CNT_W'(1);
            end
         end
         ST_HOLD:  reeval = sampleChanged;
         default:  reeval = 1'b1;
      endcase
      if (reeval) begin
         if (singleAnode) begin
            stateD = ST_SETTLE;
            cntD   = CNT_W'(1);
         end else begin
            stateD    = ST_IDLE;
            cntD      = '0;
            multiErrD = multiAnode && sampleChanged;
         end
      end
   end

   logic [3:0] decNibble;
   logic       decValid;
   logic       decBlank;

   seg7_decode u_decode (
      .pattern_i (~segQ),
      .nibble_o  (decNibble),
      .valid_o   (decValid),
      .blank_o   (decBlank)
   );

   logic [15:0] digitsQ, digitsD;
   logic [3:0]  validQ, validD;
   logic [3:0]  blankQ, blankD;
   logic [3:0]  dpOutQ, dpOutD;
   logic [3:0]  seenQ, seenD;
   logic [3:0]  seenNext;
   logic        frameQ, frameD;
   logic        multiErrQ;
   logic [TO_W-1:0] toQ, toD;

   always_comb begin
      digitsD  = digitsQ;
      validD   = validQ;
      blankD   = blankQ;
      dpOutD   = dpOutQ;
      seenD    = seenQ;
      seenNext = seenQ;
      frameD   = 1'b0;
      if (commit) begin
         if (decValid) begin
            digitsD[{anIdx, 2'b00} +: 4] = decNibble;
            validD[anIdx] = 1'b1;
            blankD[anIdx] = 1'b0;
         end else if (decBlank) begin
            digitsD[{anIdx, 2'b00} +: 4] = 4'h0;
            validD[anIdx] = 1'b0;
            blankD[anIdx] = 1'b1;
         end else begin
            validD[anIdx] = 1'b0;
            blankD[anIdx] = 1'b0;
         end
         dpOutD[anIdx]   = ~dpQ;
         seenNext[anIdx] = 1'b1;
         if (seenNext == 4'b1111) begin
            frameD = 1'b1;
            seenD  = 4'b0000;
         end else begin
            seenD = seenNext;
         end
      end
   end

   always_comb begin
      toD = toQ;
      if (commit) begin
         toD = '0;
      end else if (toQ != TO_MAX) begin
         toD = toQ + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digitsQ   <= '0;
         validQ    <= 4'b0000;
         blankQ    <= 4'b1111;
         dpOutQ    <= 4'b0000;
         seenQ     <= 4'b0000;
         frameQ    <= 1'b0;
         multiErrQ <= 1'b0;
         toQ       <= '0;
      end else begin
         digitsQ   <= digitsD;
         validQ    <= validD;
         blankQ    <= blankD;
         dpOutQ    <= dpOutD;
         seenQ     <= seenD;
         frameQ    <= frameD;
         multiErrQ <= multiErrD;
         toQ       <= toD;
      end
   end

   assign digits     = digitsQ;
   assign valid      = validQ;
   assign blank      = blankQ;
   assign dp_out     = dpOutQ;
   assign frame_done = frameQ;
   assign multi_err  = multiErrQ;
   assign stale      = (toQ == TO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed bench for seg_scan_decoder against a run-length based reference model.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

   localparam int STABLE  = 16;
   localparam int TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an = 4'b1111;
   logic [6:0]  seg = 7'h7F;
   logic        dp = 1'b1;
   logic [15:0] digits;
   logic [3:0]  valid, blank, dp_out;
   logic        frame_done, stale, multi_err;

   int total = 0;
   int bad = 0;
   int frameCnt = 0;
   int multiCnt = 0;

   always #5 clk = ~clk;

   seg_scan_decoder #(
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .digits     (digits),
      .valid      (valid),
      .blank      (blank),
      .dp_out     (dp_out),
      .frame_done (frame_done),
      .stale      (stale),
      .multi_err  (multi_err)
   );

   logic [6:0] patTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic int lookupPat(input logic [6:0] p);
      for (int k = 0; k < 16; k++) begin
         if (patTab[k] == p) return k;
      end
      return -1;
   endfunction

   // Reference model: a digit commits when a single-anode sample has been seen for exactly STABLE edges
   logic [15:0] mDigits;
   logic [3:0]  mValid, mBlank, mDpOut, seenM;
   logic        mFrame, mStale, mMulti;
   logic [11:0] curS, newS, syncA, syncB;
   logic [6:0]  pat;
   int          runLen, toCnt, nLow, pos, k;
   logic        committed;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mDigits = '0; mValid = 4'h0; mBlank = 4'hF; mDpOut = 4'h0; seenM = 4'h0;
         mFrame = 1'b0; mStale = 1'b0; mMulti = 1'b0;
         curS = '1; runLen = 0; toCnt = 0; syncA = '1; syncB = '1;
      end else begin
`ifdef SEG_SCAN_DECODER_SYNC_EN
         newS = syncB;
         syncB = syncA;
         syncA = {an, seg, dp};
`else
         newS = {an, seg, dp};
`endif
         mFrame = 1'b0;
         mMulti = 1'b0;
         committed = 1'b0;
         nLow = 0;
         pos = 0;
         for (int i = 0; i < 4; i++) begin
            if (!curS[8+i]) begin
               nLow++;
               pos = i;
            end
         end
         if (nLow == 1 && runLen == STABLE) begin
            committed = 1'b1;
            pat = ~curS[7:1];
            k = lookupPat(pat);
            if (k >= 0) begin
               mDigits[pos*4 +: 4] = 4'(k);
               mValid[pos] = 1'b1;
               mBlank[pos] = 1'b0;
            end else if (pat == 7'h00) begin
               mDigits[pos*4 +: 4] = 4'h0;
               mValid[pos] = 1'b0;
               mBlank[pos] = 1'b1;
            end else begin
               mValid[pos] = 1'b0;
               mBlank[pos] = 1'b0;
            end
            mDpOut[pos] = ~curS[0];
            seenM[pos] = 1'b1;
            if (seenM == 4'hF) begin
               mFrame = 1'b1;
               seenM = 4'h0;
            end
         end
         if (nLow > 1 && runLen == 1) mMulti = 1'b1;
         if (committed) toCnt = 0;
         else if (toCnt < TIMEOUT) toCnt++;
         mStale = (toCnt == TIMEOUT);
         if (runLen > 0 && newS == curS) begin
            if (runLen <= STABLE) runLen++;
         end else begin
            curS = newS;
            runLen = 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input logic d, input int cycles);
      an = a;
      seg = s;
      dp = d;
      repeat (cycles) @(negedge clk);
   endtask

   always @(negedge clk) begin
      checkOutput("digits", digits, mDigits);
      checkOutput("valid", {12'h0, valid}, {12'h0, mValid});
      checkOutput("blank", {12'h0, blank}, {12'h0, mBlank});
      checkOutput("dp_out", {12'h0, dp_out}, {12'h0, mDpOut});
      checkOutput("frame_done", {15'h0, frame_done}, {15'h0, mFrame});
      checkOutput("stale", {15'h0, stale}, {15'h0, mStale});
      checkOutput("multi_err", {15'h0, multi_err}, {15'h0, mMulti});
      if (frame_done) frameCnt++;
      if (multi_err) multiCnt++;
   end

   initial begin
      logic [3:0] ra;
      logic [6:0] rs;
      int         cat;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("lit_reset_digits", digits, 16'h0000);
      checkOutput("lit_reset_blank", {12'h0, blank}, 16'h000F);
      checkOutput("lit_reset_valid", {12'h0, valid}, 16'h0000);
      rst_n = 1'b1;

      // All segments lit on the leftmost digit decodes as 8
      applyStimulus(4'b0111, 7'h00, 1'b1, 16);
      checkOutput("lit_before_commit_valid", {12'h0, valid}, 16'h0000);
      @(negedge clk);
      checkOutput("lit_d3_nibble", {12'h0, digits[15:12]}, 16'h0008);
      checkOutput("lit_d3_valid", {12'h0, valid}, 16'h0008);
      checkOutput("lit_d3_blank", {12'h0, blank}, 16'h0007);
      checkOutput("lit_d3_frames", 16'(frameCnt), 16'd0);
      repeat (3) @(negedge clk);

      applyStimulus(4'b0111, ~7'h06, 1'b1, 20);
      applyStimulus(4'b1011, ~7'h5B, 1'b1, 20);
      applyStimulus(4'b1101, ~7'h4F, 1'b1, 20);
      applyStimulus(4'b1110, ~7'h66, 1'b1, 20);
      checkOutput("lit_scan_digits", digits, 16'h1234);
      checkOutput("lit_scan_valid", {12'h0, valid}, 16'h000F);
      checkOutput("lit_scan_frames", 16'(frameCnt), 16'd1);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'b1110, (i % 2 == 0) ? ~7'h06 : ~7'h5B, 1'b1, 8);
      end
      checkOutput("lit_glitch_digits", digits, 16'h1234);
      checkOutput("lit_glitch_valid", {12'h0, valid}, 16'h000F);

      multiCnt = 0;
      applyStimulus(4'b0011, 7'h7F, 1'b1, 5);
      applyStimulus(4'b1111, 7'h7F, 1'b1, 105);
      checkOutput("lit_multi_pulses", 16'(multiCnt), 16'd1);
      checkOutput("lit_stale_set", {15'h0, stale}, 16'h0001);
      checkOutput("lit_multi_digits", digits, 16'h1234);

      applyStimulus(4'b1011, ~7'h77, 1'b0, 20);
      checkOutput("lit_stale_clear", {15'h0, stale}, 16'h0000);
      checkOutput("lit_a_digits", digits, 16'h1A34);
      checkOutput("lit_a_dp", {12'h0, dp_out}, 16'h0004);

      // Reset lands while the new digit is ten samples into settling
      applyStimulus(4'b1101, 7'h02, 1'b1, 11);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("lit_midrst_digits", digits, 16'h0000);
      checkOutput("lit_midrst_valid", {12'h0, valid}, 16'h0000);
      checkOutput("lit_midrst_blank", {12'h0, blank}, 16'h000F);
      checkOutput("lit_midrst_stale", {15'h0, stale}, 16'h0000);
      rst_n = 1'b1;
      repeat (16) @(negedge clk);
      checkOutput("lit_postrst_early", {12'h0, valid}, 16'h0000);
      @(negedge clk);
      checkOutput("lit_postrst_digits", digits, 16'h0060);
      checkOutput("lit_postrst_valid", {12'h0, valid}, 16'h0002);
      checkOutput("lit_postrst_blank", {12'h0, blank}, 16'h000D);

      for (int n = 0; n < 80; n++) begin
         cat = $urandom_range(0, 9);
         if (cat <= 5) begin
            ra = 4'hF;
            ra[$urandom_range(0, 3)] = 1'b0;
         end else if (cat == 6) begin
            ra = 4'hF;
         end else begin
            ra = 4'($urandom_range(0, 15));
            if (ra == 4'hF || ra == 4'hE || ra == 4'hD || ra == 4'hB || ra == 4'h7) ra = 4'b1001;
         end
         cat = $urandom_range(0, 7);
         if (cat <= 5) rs = ~patTab[$urandom_range(0, 15)];
         else if (cat == 6) rs = 7'h7F;
         else rs = 7'($urandom_range(0, 127));
         applyStimulus(ra, rs, 1'($urandom_range(0, 1)), $urandom_range(1, 40));
      end
      applyStimulus(4'b1111, 7'h7F, 1'b1, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
